md5_bus_master: RTL and testbench

- Initiator for the MD5 core's register bus (cs/we/address/write_data/read_data); it sits between a block-producing client and the MD5 register slave.
- Accepts one 512-bit block plus an init/next flag from the client.
- Sequences the full transaction on the bus: wait for ready, write 16 block words, write CTRL, poll STATUS, read 4 digest words.
- Returns the 128-bit digest with a one-cycle valid strobe; a timeout guards both polling phases.

---
 rtl/md5_bus_pkg.sv | 40 ++++
 rtl/md5_bus_master.sv | 203 ++++++++++++++++++++
 tb/tb_md5_bus_master.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md5_bus_pkg.sv
// Register map, control/status bit positions and FSM encoding shared by the
// MD5 register-bus master and anything that talks to the same slave.
package md5_bus_pkg;

  localparam logic [7:0] ADDR_NAME0   = 8'h00;
  localparam logic [7:0] ADDR_NAME1   = 8'h01;
  localparam logic [7:0] ADDR_VERSION = 8'h02;
  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
  localparam logic [7:0] ADDR_BLOCK15 = 8'h2f;
  localparam logic [7:0] ADDR_DIGEST0 = 8'h40;
  localparam logic [7:0] ADDR_DIGEST3 = 8'h43;

  localparam int unsigned CTRL_INIT_BIT    = 0;
  localparam int unsigned CTRL_NEXT_BIT    = 1;
  localparam int unsigned STATUS_READY_BIT = 0;

  typedef enum logic [3:0] {
    StIdle,
    StChk,
    StWblk,
    StWctl,
    StWait,
    StPoll,
    StRdig,
    StDone,
    StAbort
  } state_e;

  // CTRL carries exactly one of init/next.
  function automatic logic [31:0] ctrl_word(input logic init);
    logic [31:0] w;
    w = '0;
    w[CTRL_INIT_BIT] = init;
    w[CTRL_NEXT_BIT] = ~init;
    return w;
  endfunction

endpackage

// File: rtl/md5_bus_master.sv
// Bus initiator that pushes one 512-bit block into the MD5 register slave,
// starts the core, polls for completion and returns the 128-bit digest.
module md5_bus_master
  import md5_bus_pkg::*;
#(
  parameter int unsigned POLL_DELAY     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         first,
  input  logic [511:0] block,
  output logic         busy,
  output logic         digest_valid,
  output logic [127:0] digest,
  output logic         error,
  output logic         cs,
  output logic         we,
  output logic [7:0]   address,
  output logic [31:0]  write_data,
  input  logic [31:0]  read_data
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DlyW = $clog2(POLL_DELAY + 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT_CYCLES);

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [TmoW-1:0] tmo_q, tmo_d, tmo_inc;
  logic [DlyW-1:0] dly_q, dly_d;
  logic [511:0]   blk_q, blk_d;
  logic           first_q, first_d;
  logic [127:0]   shadow_q, shadow_d;
  logic [127:0]   digest_q, digest_d;
  logic           busy_q, busy_d;
  logic           dv_q, dv_d;
  logic           err_q, err_d;
  logic           cs_q, cs_d;
  logic           we_q, we_d;
  logic [7:0]     addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;

  assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;

  // Bus outputs are registered, so every transition also sets up the access
  // that the next state performs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    dly_d    = dly_q;
    blk_d    = blk_q;
    first_d  = first_q;
    shadow_d = shadow_q;
    digest_d = digest_q;
    busy_d   = busy_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    cs_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          blk_d   = block;
          first_d = first;
          busy_d  = 1'b1;
          tmo_d   = '0;
          state_d = StChk;
          cs_d    = 1'b1;
          addr_d  = ADDR_STATUS;
        end
      end

      StChk, StPoll: begin
        if (read_data[STATUS_READY_BIT]) begin
          idx_d = '0;
          cs_d  = 1'b1;
          if (state_q == StChk) begin
            state_d = StWblk;
            we_d    = 1'b1;
            addr_d  = ADDR_BLOCK0;
            wdata_d = blk_q[511:480];
            blk_d   = {blk_q[479:0], 32'h0};
          end else begin
            state_d = StRdig;
            addr_d  = ADDR_DIGEST0;
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TmoLimit) begin
            state_d = StAbort;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            cs_d   = 1'b1;
            addr_d = ADDR_STATUS;
          end
        end
      end

      StWblk: begin
        cs_d = 1'b1;
        we_d = 1'b1;
        if (idx_q == 4'd15) begin
          state_d = StWctl;
          addr_d  = ADDR_CTRL;
          wdata_d = ctrl_word(first_q);
        end else begin
          idx_d   = idx_q + 4'd1;
          addr_d  = ADDR_BLOCK0 + 8'(idx_q) + 8'd1;
          wdata_d = blk_q[511:480];
          blk_d   = {blk_q[479:0], 32'h0};
        end
      end

      StWctl: begin
        state_d = StWait;
        dly_d   = DlyW'(POLL_DELAY);
      end

      StWait: begin
        if (dly_q == DlyW'(1)) begin
          state_d = StPoll;
          tmo_d   = '0;
          cs_d    = 1'b1;
          addr_d  = ADDR_STATUS;
        end else begin
          dly_d = dly_q - DlyW'(1);
        end
      end

      StRdig: begin
        // Words shift in from the bottom so DIGEST0 ends up in [127:96].
        shadow_d = {shadow_q[95:0], read_data};
        if (idx_q == 4'd3) begin
          state_d  = StDone;
          digest_d = {shadow_q[95:0], read_data};
          dv_d     = 1'b1;
          busy_d   = 1'b0;
        end else begin
          idx_d  = idx_q + 4'd1;
          cs_d   = 1'b1;
          addr_d = ADDR_DIGEST0 + 8'(idx_q) + 8'd1;
        end
      end

      StDone, StAbort: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      tmo_q    <= '0;
      dly_q    <= '0;
      blk_q    <= '0;
      first_q  <= 1'b0;
      shadow_q <= '0;
      digest_q <= '0;
      busy_q   <= 1'b0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      dly_q    <= dly_d;
      blk_q    <= blk_d;
      first_q  <= first_d;
      shadow_q <= shadow_d;
      digest_q <= digest_d;
      busy_q   <= busy_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign busy         = busy_q;
  assign digest_valid = dv_q;
  assign digest       = digest_q;
  assign error        = err_q;
  assign cs           = cs_q;
  assign we           = we_q;
  assign address      = addr_q;
  assign write_data   = wdata_q;

endmodule

// File: tb/tb_md5_bus_master.sv
// Self-checking bench: behavioural register slave with programmable ready
// delays, bus-trace recorder and a transaction-level reference model.
`timescale 1ns/1ps
module tb_md5_bus_master;

  localparam int PD  = 2;
  localparam int TMO = 8;

  typedef struct {
    int          cyc;
    logic        we;
    logic [7:0]  a;
    logic [31:0] d;
  } acc_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         first = 1'b0;
  logic [511:0] block = '0;
  logic         busy, digest_valid, error, cs, we;
  logic [127:0] digest;
  logic [7:0]   address;
  logic [31:0]  write_data, read_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int pre_cfg = 0;
  int post_cfg = 0;
  int zcnt = 0;
  int we_bad = 0;
  bit txn_done = 1'b0;
  logic [31:0] dig_words [4];
  acc_t log_q[$];
  acc_t exp_q[$];
  int   dv_cyc[$];
  int   err_cyc[$];

  md5_bus_master #(
    .POLL_DELAY    (PD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .first       (first),
    .block       (block),
    .busy        (busy),
    .digest_valid(digest_valid),
    .digest      (digest),
    .error       (error),
    .cs          (cs),
    .we          (we),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data)
  );

  always #5 clk = ~clk;

  // Slave: ready drops for pre_cfg cycles after an accepted start and for
  // post_cfg cycles after the CTRL write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) zcnt <= 0;
    else if (cs && we && address == 8'h08) zcnt <= post_cfg;
    else if (start && !busy) zcnt <= pre_cfg;
    else if (zcnt != 0) zcnt <= zcnt - 1;
  end

  always_comb begin
    read_data = 32'hdead_beef;
    if (address == 8'h09) read_data = {31'h2aaa_aaaa, zcnt == 0};
    else if (address[7:2] == 6'h10) read_data = dig_words[address[1:0]];
  end

  always @(negedge clk) begin
    acc_t e;
    if (cs) begin
      e.cyc = cyc; e.we = we; e.a = address; e.d = write_data;
      log_q.push_back(e);
    end
    if (!cs && we) we_bad <= we_bad + 1;
    if (digest_valid) dv_cyc.push_back(cyc);
    if (error) err_cyc.push_back(cyc);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic acc_t mk(input logic w, input logic [7:0] a, input logic [31:0] d);
    acc_t e;
    e.cyc = 0; e.we = w; e.a = a; e.d = d;
    return e;
  endfunction

  function automatic int polls_for(input int post_n);
    return (post_n > PD) ? post_n - PD + 1 : 1;
  endfunction

  function automatic void build_expected(input logic f, input logic [511:0] b,
                                         input int pre_n, input int post_n);
    exp_q.delete();
    if (pre_n >= TMO) begin
      for (int i = 0; i < TMO; i++) exp_q.push_back(mk(1'b0, 8'h09, 32'h0));
      return;
    end
    for (int i = 0; i <= pre_n; i++) exp_q.push_back(mk(1'b0, 8'h09, 32'h0));
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(1'b1, 8'(32 + i), b[511 - 32*i -: 32]));
    exp_q.push_back(mk(1'b1, 8'h08, f ? 32'h1 : 32'h2));
    if (post_n - PD >= TMO) begin
      for (int i = 0; i < TMO; i++) exp_q.push_back(mk(1'b0, 8'h09, 32'h0));
      return;
    end
    for (int i = 0; i < polls_for(post_n); i++) exp_q.push_back(mk(1'b0, 8'h09, 32'h0));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 8'(64 + i), 32'h0));
  endfunction

  function automatic int lat_for(input int pre_n, input int post_n);
    return (pre_n + 1) + 16 + 1 + PD + polls_for(post_n) + 4 + 1;
  endfunction

  function automatic logic [127:0] exp_digest();
    return {dig_words[0], dig_words[1], dig_words[2], dig_words[3]};
  endfunction

  function automatic int first_diff();
    int n;
    n = (log_q.size() > exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= log_q.size() || i >= exp_q.size()) return i;
      if (log_q[i].we !== exp_q[i].we || log_q[i].a !== exp_q[i].a) return i;
      if (exp_q[i].we && log_q[i].d !== exp_q[i].d) return i;
    end
    return -1;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  // Drives one request from a negedge and waits (bounded) for busy to fall.
  task automatic do_txn(input logic f, input logic [511:0] b, input int pre_n,
                        input int post_n, input int poke_at, input bit tail);
    pre_cfg = pre_n; post_cfg = post_n;
    log_q.delete(); dv_cyc.delete(); err_cyc.delete();
    first = f; block = b; start = 1'b1; acc_cyc = cyc;
    @(negedge clk);
    start = 1'b0; block = rand_block(); first = ~f;
    txn_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      start = (i == poke_at);
      if (!busy) begin txn_done = 1'b1; break; end
      @(negedge clk);
    end
    start = 1'b0;
    if (tail) repeat (4) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, digest_valid, error} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {busy, digest_valid, error});
    end
    checks++;
    if ({cs, we} !== 2'b00) begin
      errors++; $display("FAIL reset_bus_ctl: got %b want 00", {cs, we});
    end
    checks++;
    if ({address, write_data} !== 40'h0) begin
      errors++; $display("FAIL reset_bus_data: got %h want 0", {address, write_data});
    end
    checks++;
    if (digest !== 128'h0) begin
      errors++; $display("FAIL reset_digest: got %h want 0", digest);
    end
  endtask

  task automatic test_basic(input logic f);
    logic [511:0] b;
    int d;
    dig_words[0] = 32'h1111_1111; dig_words[1] = 32'h2222_2222;
    dig_words[2] = 32'h3333_3333; dig_words[3] = 32'h4444_4444;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = 32'(i);
    build_expected(f, b, 0, 0);
    do_txn(f, b, 0, 0, -1, 1'b1);
    checks++;
    if (!txn_done) begin errors++; $display("FAIL basic_done: busy still %b want 0", busy); end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL basic_trace(first=%0b): differs at access %0d, got %0d accesses want %0d",
               f, d, log_q.size(), exp_q.size());
    end
    checks++;
    if (dv_cyc.size() != 1) begin
      errors++; $display("FAIL basic_dv_count: got %0d want 1", dv_cyc.size());
    end else begin
      checks++;
      if (dv_cyc[0] - acc_cyc != 26) begin
        errors++; $display("FAIL basic_latency: got %0d want 26", dv_cyc[0] - acc_cyc);
      end
    end
    checks++;
    if (digest !== 128'h11111111222222223333333344444444) begin
      errors++; $display("FAIL basic_digest: got %h want 11111111222222223333333344444444", digest);
    end
    checks++;
    if (err_cyc.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle: got err=%0d busy=%b want 0 0", err_cyc.size(), busy);
    end
  endtask

  task automatic test_slow_ready();
    logic [511:0] b;
    int d;
    b = rand_block();
    build_expected(1'b1, b, 0, 5);
    do_txn(1'b1, b, 0, 5, -1, 1'b1);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL slow_trace: differs at access %0d, got %0d accesses want %0d",
               d, log_q.size(), exp_q.size());
    end else begin
      checks++;
      if (log_q[18].cyc - log_q[17].cyc != PD + 1) begin
        errors++; $display("FAIL slow_gap: got %0d want %0d", log_q[18].cyc - log_q[17].cyc, PD + 1);
      end
    end
    checks++;
    if (dv_cyc.size() != 1 || digest !== exp_digest()) begin
      errors++; $display("FAIL slow_digest: got %h (%0d pulses) want %h", digest, dv_cyc.size(),
                         exp_digest());
    end
  endtask

  task automatic test_timeout();
    logic [127:0] prev;
    logic [511:0] b;
    int d;
    prev = digest;
    dig_words[0] = 32'hcafe_0000; dig_words[1] = 32'hcafe_0001;
    dig_words[2] = 32'hcafe_0002; dig_words[3] = 32'hcafe_0003;
    b = rand_block();
    build_expected(1'b1, b, 0, 1000);
    do_txn(1'b1, b, 0, 1000, -1, 1'b1);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++; $display("FAIL tmo_poll_trace: differs at access %0d, got %0d accesses want %0d",
                         d, log_q.size(), exp_q.size());
    end
    checks++;
    if (err_cyc.size() != 1 || dv_cyc.size() != 0) begin
      errors++; $display("FAIL tmo_poll_pulses: got err=%0d dv=%0d want 1 0",
                         err_cyc.size(), dv_cyc.size());
    end else begin
      checks++;
      if (err_cyc[0] - acc_cyc != 1 + 16 + 1 + PD + TMO + 1) begin
        errors++; $display("FAIL tmo_poll_when: got %0d want %0d", err_cyc[0] - acc_cyc,
                           1 + 16 + 1 + PD + TMO + 1);
      end
    end
    checks++;
    if (digest !== prev || busy !== 1'b0) begin
      errors++; $display("FAIL tmo_poll_state: got digest %h busy %b want %h 0", digest, busy, prev);
    end
    // Ready never comes during the pre-write check.
    build_expected(1'b0, b, 20, 0);
    do_txn(1'b0, b, 20, 0, -1, 1'b1);
    d = first_diff();
    checks++;
    if (d != -1 || err_cyc.size() != 1 || dv_cyc.size() != 0) begin
      errors++; $display("FAIL tmo_chk: got %0d accesses err=%0d dv=%0d want %0d 1 0",
                         log_q.size(), err_cyc.size(), dv_cyc.size(), exp_q.size());
    end
    checks++;
    if (digest !== prev) begin
      errors++; $display("FAIL tmo_chk_digest: got %h want %h", digest, prev);
    end
  endtask

  task automatic test_start_ignored();
    logic [511:0] b;
    int d;
    b = rand_block();
    build_expected(1'b1, b, 0, 0);
    do_txn(1'b1, b, 0, 0, 5, 1'b1);
    repeat (20) @(negedge clk);
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++; $display("FAIL ignore_trace: differs at access %0d, got %0d accesses want %0d",
                         d, log_q.size(), exp_q.size());
    end
    checks++;
    if (dv_cyc.size() != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL ignore_pulses: got dv=%0d busy=%b want 1 0", dv_cyc.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] b;
    int d;
    for (int i = 0; i < 4; i++) dig_words[i] = $urandom();
    do_txn(1'b1, rand_block(), 0, 0, -1, 1'b0);
    checks++;
    if (digest_valid !== 1'b1 || digest !== exp_digest()) begin
      errors++; $display("FAIL b2b_first: got dv=%b %h want 1 %h", digest_valid, digest,
                         exp_digest());
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) dig_words[i] = $urandom();
    b = rand_block();
    build_expected(1'b0, b, 0, 0);
    do_txn(1'b0, b, 0, 0, -1, 1'b1);
    d = first_diff();
    checks++;
    if (d != -1 || dv_cyc.size() != 1 || digest !== exp_digest()) begin
      errors++; $display("FAIL b2b_second: diff at %0d, dv=%0d digest %h want %h", d,
                         dv_cyc.size(), digest, exp_digest());
    end
  endtask

  task automatic test_random();
    logic [511:0] b;
    logic f;
    int pre_n, post_n, d;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) dig_words[i] = $urandom();
      b = rand_block();
      f = 1'($urandom_range(0, 1));
      pre_n = $urandom_range(0, 3);
      post_n = $urandom_range(0, 6);
      build_expected(f, b, pre_n, post_n);
      do_txn(f, b, pre_n, post_n, -1, 1'b1);
      d = first_diff();
      checks++;
      if (d != -1) begin
        errors++; $display("FAIL rand%0d_trace: differs at access %0d, got %0d want %0d", n, d,
                           log_q.size(), exp_q.size());
      end
      checks++;
      if (dv_cyc.size() != 1) begin
        errors++; $display("FAIL rand%0d_dv: got %0d pulses want 1", n, dv_cyc.size());
      end else if (dv_cyc[0] - acc_cyc != lat_for(pre_n, post_n)) begin
        errors++; $display("FAIL rand%0d_latency: got %0d want %0d", n, dv_cyc[0] - acc_cyc,
                           lat_for(pre_n, post_n));
      end
      checks++;
      if (digest !== exp_digest()) begin
        errors++; $display("FAIL rand%0d_digest: got %h want %h", n, digest, exp_digest());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    pre_cfg = 0; post_cfg = 0;
    first = 1'b1; block = rand_block(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cs && address[7:2] == 6'h10) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_reach: got no digest read want one"); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({cs, we, busy} !== 3'b000) begin
      errors++; $display("FAIL rstmid_bus: got cs/we/busy %b want 000", {cs, we, busy});
    end
    checks++;
    if (digest !== 128'h0 || address !== 8'h0) begin
      errors++; $display("FAIL rstmid_regs: got digest %h addr %h want 0 0", digest, address);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({cs, busy, digest_valid, error} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_idle: got %b want 0000", {cs, busy, digest_valid, error});
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) dig_words[i] = 32'h0;
    test_reset();
    test_basic(1'b1);
    test_basic(1'b0);
    test_slow_ready();
    test_timeout();
    test_start_ignored();
    test_back_to_back();
    test_random();
    test_reset_mid();
    checks++;
    if (we_bad != 0) begin
      errors++; $display("FAIL we_without_cs: got %0d cycles want 0", we_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
